// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-flop synchronizer, 3-sample majority voting and a valid/ready output register.
// Optional parity checking is compiled in when the macro UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_rx_param #(
  parameter int FREQ       = 50_000_000,
  parameter int RATE       = 2_000_000,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_vld,
  input  logic                 i_rdy,
  output logic                 o_frame_err,
  output logic                 o_parity_err,
  output logic                 o_overrun
);

  localparam int            DIV       = FREQ / RATE;
  localparam int            CW        = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(DIV / 2);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  generate
    if (DIV < 4 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
      $error("uart_rx_param: unsupported configuration (DIV must be >= 4, DATA_BITS 5..9, STOP_BITS 1..2)");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  function automatic logic parity_err_calc(input logic [DATA_BITS-1:0] d, input logic p, input logic odd);
    return (^d) ^ p ^ odd;
  endfunction
`endif

  logic [1:0]           sync_r;
  logic                 rx_s, rx_d1_r, rx_d2_r, maj_s, fall_s;
  logic [CW-1:0]        cnt_r;
  logic                 en_s;
  state_t               state_r, state_n_s;
  logic [3:0]           bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 ferr_r, done_r;
  logic                 start_s, bit_clr_s, bit_inc_s, shift_s, stop_s, err_clr_s, done_s, perr_cap_s;

  assign rx_s   = sync_r[1];
  assign maj_s  = (rx_s & rx_d1_r) | (rx_s & rx_d2_r) | (rx_d1_r & rx_d2_r);
  assign fall_s = rx_d1_r & ~rx_s;
  assign en_s   = (state_r != ST_IDLE) && (cnt_r == CNT_MAX);

  // Input synchronizer and 3-deep sample history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 2'b11;
      rx_d1_r <= 1'b1;
      rx_d2_r <= 1'b1;
    end else begin
      sync_r  <= {sync_r[0], i_rx};
      rx_d1_r <= rx_s;
      rx_d2_r <= rx_d1_r;
    end
  end

  // Baud counter: re-phased on start detect so en lands mid-bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (start_s) begin
      cnt_r <= CNT_HALF;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_n_s  = state_r;
    start_s    = 1'b0;
    bit_clr_s  = 1'b0;
    bit_inc_s  = 1'b0;
    shift_s    = 1'b0;
    stop_s     = 1'b0;
    err_clr_s  = 1'b0;
    done_s     = 1'b0;
    perr_cap_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          start_s   = 1'b1;
          state_n_s = ST_START;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (!en_s) begin
          state_n_s = ST_START;
        end else if (maj_s) begin
          state_n_s = ST_IDLE;
        end else begin
          bit_clr_s = 1'b1;
          err_clr_s = 1'b1;
          state_n_s = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!en_s) begin
          state_n_s = ST_DATA;
        end else if (bit_cnt_r == LAST_DATA) begin
          shift_s   = 1'b1;
          bit_clr_s = 1'b1;
`ifdef UART_RX_PARITY_EN
          state_n_s = ST_PARITY;
`else
          state_n_s = ST_STOP;
`endif
        end else begin
          shift_s   = 1'b1;
          bit_inc_s = 1'b1;
          state_n_s = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (en_s) begin
          perr_cap_s = 1'b1;
          state_n_s  = ST_STOP;
        end else begin
          state_n_s  = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (!en_s) begin
          state_n_s = ST_STOP;
        end else if (bit_cnt_r == LAST_STOP) begin
          stop_s    = 1'b1;
          done_s    = 1'b1;
          state_n_s = ST_IDLE;
        end else begin
          stop_s    = 1'b1;
          bit_inc_s = 1'b1;
          state_n_s = ST_STOP;
        end
      end
      default: begin
        state_n_s = ST_IDLE;
      end
    endcase
  end

  // Bit counter, shift register and per-frame framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= '0;
      ferr_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      done_r <= done_s;
      if (bit_clr_s) begin
        bit_cnt_r <= 4'd0;
      end else if (bit_inc_s) begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
      end
      if (shift_s) begin
        shift_r <= {maj_s, shift_r[DATA_BITS-1:1]};
      end
      if (err_clr_s) begin
        ferr_r <= 1'b0;
      end else if (stop_s) begin
        ferr_r <= ferr_r | ~maj_s;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic perr_r;

  // Parity error captured from the parity slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else if (err_clr_s) begin
      perr_r <= 1'b0;
    end else if (perr_cap_s) begin
      perr_r <= parity_err_calc(shift_r, maj_s, PARITY_ODD);
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  // Output holding register: a completed frame is dropped if the held word is not being taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data       <= '0;
      o_vld        <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_parity_err <= 1'b0;
`endif
    end else begin
      o_overrun <= 1'b0;
      if (done_r) begin
        if (!o_vld || i_rdy) begin
          o_data       <= shift_r;
          o_frame_err  <= ferr_r;
          o_vld        <= 1'b1;
`ifdef UART_RX_PARITY_EN
          o_parity_err <= perr_r;
`endif
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_vld && i_rdy) begin
        o_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed, table-driven bench for uart_rx_param (DIV = 25); parity cases run only when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_rx_param;

  localparam int DIV = 25;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rx    = 1'b1;
  logic       i_rdy = 1'b1;
  logic [7:0] o_data;
  logic       o_vld, o_frame_err, o_parity_err, o_overrun;

  uart_rx_param dut (
    .clk(clk), .rst_n(rst_n), .i_rx(rx), .o_data(o_data), .o_vld(o_vld), .i_rdy(i_rdy),
    .o_frame_err(o_frame_err), .o_parity_err(o_parity_err), .o_overrun(o_overrun)
  );

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } rec_t;

  typedef struct {
    logic [7:0] data;
    bit         stop0;
    int         glitch;
    logic [7:0] exp_data;
    bit         exp_ferr;
  } vec_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   ovr_cnt  = 0;
  rec_t q[$];

`ifdef UART_RX_PARITY_EN
  logic       rx2 = 1'b1;
  logic [6:0] o_data2;
  logic       o_vld2, o_ferr2, o_perr2, o_ovr2;
  rec_t       q2[$];

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_ODD(1'b0)) dut7 (
    .clk(clk), .rst_n(rst_n), .i_rx(rx2), .o_data(o_data2), .o_vld(o_vld2), .i_rdy(1'b1),
    .o_frame_err(o_ferr2), .o_parity_err(o_perr2), .o_overrun(o_ovr2)
  );

  always @(negedge clk) begin
    if (o_vld2) q2.push_back('{data: 9'(o_data2), ferr: o_ferr2, perr: o_perr2});
  end
`endif

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_vld && i_rdy) q.push_back('{data: 9'(o_data), ferr: o_frame_err, perr: o_parity_err});
    if (o_overrun) ovr_cnt++;
  end

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic set_line(input bit tgt, input logic v);
`ifdef UART_RX_PARITY_EN
    if (tgt) rx2 = v;
    else rx = v;
`else
    if (!tgt) rx = v;
`endif
  endtask

  task automatic send_frame(input logic [8:0] d, input int nbits, input int nstop, input bit use_par,
                            input bit par_odd, input bit par_flip, input bit stop0, input int glitch_bit,
                            input bit tgt);
    logic b, p;
    set_line(tgt, 1'b0);
    hold(DIV);
    p = par_odd;
    for (int i = 0; i < nbits; i++) begin
      b = d[i];
      p = p ^ b;
      set_line(tgt, b);
      if (i == glitch_bit) begin
        hold(12);
        set_line(tgt, ~b);
        hold(1);
        set_line(tgt, b);
        hold(DIV - 13);
      end else begin
        hold(DIV);
      end
    end
    if (use_par) begin
      set_line(tgt, p ^ par_flip);
      hold(DIV);
    end
    for (int s = 0; s < nstop; s++) begin
      set_line(tgt, ~stop0);
      hold(DIV);
    end
    set_line(tgt, 1'b1);
  endtask

  task automatic wait_q();
    for (int k = 0; k < 4 * DIV; k++) begin
      if (q.size() != 0) break;
      hold(1);
    end
  endtask

  task automatic pop(output rec_t r);
    if (q.size() > 0) r = q.pop_front();
    else r = '{data: 'x, ferr: 1'bx, perr: 1'bx};
  endtask

  vec_t vecs[6];
  rec_t r;
  int   ovr0;

  initial begin
    vecs[0] = '{data: 8'hA5, stop0: 1'b0, glitch: -1, exp_data: 8'hA5, exp_ferr: 1'b0};
    vecs[1] = '{data: 8'h3C, stop0: 1'b1, glitch: -1, exp_data: 8'h3C, exp_ferr: 1'b1};
    vecs[2] = '{data: 8'h81, stop0: 1'b0, glitch: -1, exp_data: 8'h81, exp_ferr: 1'b0};
    vecs[3] = '{data: 8'h5A, stop0: 1'b0, glitch: 3,  exp_data: 8'h5A, exp_ferr: 1'b0};
    vecs[4] = '{data: 8'h00, stop0: 1'b0, glitch: -1, exp_data: 8'h00, exp_ferr: 1'b0};
    vecs[5] = '{data: 8'hFF, stop0: 1'b0, glitch: 0,  exp_data: 8'hFF, exp_ferr: 1'b0};

    #1 rst_n = 1'b0;
    hold(3);
    chk("rst_vld", 32'(o_vld), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_ferr", 32'(o_frame_err), 32'd0);
    chk("rst_perr", 32'(o_parity_err), 32'd0);
    chk("rst_ovr", 32'(o_overrun), 32'd0);
    rst_n = 1'b1;
    hold(DIV);

    ovr0 = ovr_cnt;
    for (int i = 0; i < 6; i++) begin
      send_frame(9'(vecs[i].data), 8, 1, PAR_ON, 1'b0, 1'b0, vecs[i].stop0, vecs[i].glitch, 1'b0);
      wait_q();
      chk($sformatf("v%0d_count", i), 32'(q.size()), 32'd1);
      pop(r);
      chk($sformatf("v%0d_data", i), 32'(r.data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_ferr", i), 32'(r.ferr), 32'(vecs[i].exp_ferr));
      chk($sformatf("v%0d_perr", i), 32'(r.perr), 32'd0);
      hold(DIV);
    end
    chk("table_no_overrun", 32'(ovr_cnt), 32'(ovr0));

    // false start: line low for only 8 cycles
    rx = 1'b0;
    hold(8);
    rx = 1'b1;
    hold(3 * DIV);
    chk("false_start_none", 32'(q.size()), 32'd0);
    chk("false_start_vld", 32'(o_vld), 32'd0);

    // overrun: consumer stalled across two frames
    i_rdy = 1'b0;
    ovr0 = ovr_cnt;
    send_frame(9'h11, 8, 1, PAR_ON, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    hold(DIV);
    send_frame(9'h22, 8, 1, PAR_ON, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    hold(2 * DIV);
    chk("ovr_vld_held", 32'(o_vld), 32'd1);
    chk("ovr_data_held", 32'(o_data), 32'h11);
    chk("ovr_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    chk("ovr_no_accept", 32'(q.size()), 32'd0);
    i_rdy = 1'b1;
    hold(1);
    chk("ovr_one_accept", 32'(q.size()), 32'd1);
    pop(r);
    chk("ovr_accept_data", 32'(r.data), 32'h11);
    chk("ovr_vld_drop", 32'(o_vld), 32'd0);
    hold(DIV);

    // reset during bit 4 of a frame
    set_line(1'b0, 1'b0);
    hold(DIV);
    for (int i = 0; i < 4; i++) begin
      set_line(1'b0, 1'b1);
      hold(DIV);
    end
    set_line(1'b0, 1'b0);
    hold(DIV / 2);
    rst_n = 1'b0;
    rx    = 1'b1;
    hold(1);
    chk("midrst_vld", 32'(o_vld), 32'd0);
    chk("midrst_data", 32'(o_data), 32'd0);
    chk("midrst_ferr", 32'(o_frame_err), 32'd0);
    hold(2);
    rst_n = 1'b1;
    hold(12 * DIV);
    chk("midrst_no_word", 32'(q.size()), 32'd0);
    chk("midrst_vld_after", 32'(o_vld), 32'd0);
    send_frame(9'hF0, 8, 1, PAR_ON, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    wait_q();
    chk("post_rst_count", 32'(q.size()), 32'd1);
    pop(r);
    chk("post_rst_data", 32'(r.data), 32'hF0);
    chk("post_rst_ferr", 32'(r.ferr), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 7E2 instance: correct then flipped parity
    for (int f = 0; f < 2; f++) begin
      send_frame(9'h55, 7, 2, 1'b1, 1'b0, f[0], 1'b0, -1, 1'b1);
      hold(2 * DIV);
      chk($sformatf("par%0d_count", f), 32'(q2.size()), 32'd1);
      if (q2.size() > 0) r = q2.pop_front();
      else r = '{data: 'x, ferr: 1'bx, perr: 1'bx};
      chk($sformatf("par%0d_data", f), 32'(r.data), 32'h55);
      chk($sformatf("par%0d_perr", f), 32'(r.perr), 32'(f[0]));
      chk($sformatf("par%0d_ferr", f), 32'(r.ferr), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
